// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding.
package seq_divider_pkg;

    // Divider control states; IDLE is the only state that accepts a new start.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Largest number of quotient bits retired per cycle that the datapath supports.
    localparam int BPC_MAX = 2;

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle of the sequential divider (start/ready/done_tick handshake).
interface seq_divider_if #(
    parameter int W = 16
);
    logic         start;
    logic         signed_op;
    logic         abort;
    logic [W-1:0] dvnd;
    logic [W-1:0] dvsr;
    logic [W-1:0] quo;
    logic [W-1:0] rmd;
    logic         div_zero;
    logic         ovf;
    logic         ready;
    logic         done_tick;

    // Requester side: issues operations and observes results.
    modport master (
        output start, signed_op, abort, dvnd, dvsr,
        input  quo, rmd, div_zero, ovf, ready, done_tick
    );

    // Divider side: accepts operations and presents results.
    modport slave (
        input  start, signed_op, abort, dvnd, dvsr,
        output quo, rmd, div_zero, ovf, ready, done_tick
    );
endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if that does not borrow.
module seq_divider_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] dvsr,
    input  logic         next_bit,
    output logic [W-1:0] rem_out,
    output logic         qbit
);
    logic [W:0]   shifted_s;
    logic [W+1:0] trial_s;
    logic         trial_unused_s;

    // A non-borrowing trial is always below the divisor, so its bit W is zero.
    assign trial_unused_s = trial_s[W];

    // Trial subtraction with one guard bit; the top bit is the borrow.
    always_comb begin
        shifted_s = {rem_in, next_bit};
        trial_s   = {1'b0, shifted_s} - {2'b00, dvsr};
        if (trial_s[W+1]) begin
            // Borrow: restore, the shifted remainder stays below the divisor.
            rem_out = shifted_s[W-1:0];
            qbit    = 1'b0;
        end else begin
            rem_out = trial_s[W-1:0];
            qbit    = 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider with signed/unsigned mode, 1 or 2
// quotient bits per cycle, divide-by-zero and signed-overflow flags, abort.
// Signed operations divide magnitudes and fix the signs afterwards, so the
// quotient truncates toward zero and the remainder follows the dividend.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int W         = 16,
    parameter int BPC       = 1,
    parameter int SIGNED_EN = 1
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int N     = W / BPC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [W-1:0] ZERO_W = {W{1'b0}};
    localparam logic [W-1:0] ONES_W = {W{1'b1}};
    localparam logic [W-1:0] MIN_W  = {1'b1, {(W-1){1'b0}}};

    // Two's-complement negation with W-bit wrap.
    function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
        neg_w = ~x + {{(W-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of x when interpreted as signed; identity for unsigned.
    function automatic logic [W-1:0] abs_w(input logic [W-1:0] x, input logic is_signed);
        if (is_signed && x[W-1]) begin
            abs_w = neg_w(x);
        end else begin
            abs_w = x;
        end
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [W-1:0]     rem_r;        // partial remainder (upper half of shift register)
    logic [W-1:0]     dvd_r;        // dividend bits shifting out, quotient bits shifting in
    logic [W-1:0]     dvsr_r;       // divisor magnitude
    logic             sign_q_r;
    logic             sign_r_r;
    logic             ovf_pend_r;
    logic [W-1:0]     quo_r;
    logic [W-1:0]     rmd_r;
    logic             div_zero_r;
    logic             ovf_r;
    logic             ready_r;
    logic             done_tick_r;

    logic             sgn_s;
    logic [W-1:0]     rem_chain_s [0:BPC];
    logic [BPC-1:0]   qbits_s;
    logic [W-1:0]     dvd_next_s;

    assign sgn_s = (SIGNED_EN != 0) ? bus.signed_op : 1'b0;

    // Chain of BPC restoring steps evaluated within one CALC cycle, MSB first.
    assign rem_chain_s[0] = rem_r;
    for (genvar g = 0; g < BPC; g++) begin : g_step
        seq_divider_step #(.W(W)) u_step (
            .rem_in   (rem_chain_s[g]),
            .dvsr     (dvsr_r),
            .next_bit (dvd_r[W-1-g]),
            .rem_out  (rem_chain_s[g+1]),
            .qbit     (qbits_s[BPC-1-g])
        );
    end

    assign dvd_next_s = {dvd_r[W-BPC-1:0], qbits_s};

    // Control FSM, operand registers and registered result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            rem_r       <= ZERO_W;
            dvd_r       <= ZERO_W;
            dvsr_r      <= ZERO_W;
            sign_q_r    <= 1'b0;
            sign_r_r    <= 1'b0;
            ovf_pend_r  <= 1'b0;
            quo_r       <= ZERO_W;
            rmd_r       <= ZERO_W;
            div_zero_r  <= 1'b0;
            ovf_r       <= 1'b0;
            ready_r     <= 1'b1;
            done_tick_r <= 1'b0;
        end else begin
            done_tick_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // start outranks abort here; abort has no effect in IDLE.
                    if (bus.start) begin
                        sign_q_r   <= sgn_s & (bus.dvnd[W-1] ^ bus.dvsr[W-1]);
                        sign_r_r   <= sgn_s & bus.dvnd[W-1];
                        ovf_pend_r <= sgn_s & (bus.dvnd == MIN_W) & (bus.dvsr == ONES_W);
                        dvd_r      <= abs_w(bus.dvnd, sgn_s);
                        dvsr_r     <= abs_w(bus.dvsr, sgn_s);
                        rem_r      <= ZERO_W;
                        cnt_r      <= CNT_ZERO;
                        ovf_r      <= 1'b0;
                        ready_r    <= 1'b0;
                        if (bus.dvsr == ZERO_W) begin
                            // Divide by zero: report immediately with the raw dividend.
                            quo_r       <= ONES_W;
                            rmd_r       <= bus.dvnd;
                            div_zero_r  <= 1'b1;
                            done_tick_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            div_zero_r <= 1'b0;
                            state_r    <= ST_CALC;
                        end
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (bus.abort) begin
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        rem_r <= rem_chain_s[BPC];
                        dvd_r <= dvd_next_s;
                        if (cnt_r == CNT_LAST) begin
                            state_r <= ST_FIX;
                        end else begin
                            cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            state_r <= ST_CALC;
                        end
                    end
                end
                ST_FIX: begin
                    if (bus.abort) begin
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        // MIN / -1 needs no special case: |MIN| negated wraps back to MIN.
                        quo_r       <= sign_q_r ? neg_w(dvd_r) : dvd_r;
                        rmd_r       <= sign_r_r ? neg_w(rem_r) : rem_r;
                        ovf_r       <= ovf_pend_r;
                        done_tick_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.quo       = quo_r;
    assign bus.rmd       = rmd_r;
    assign bus.div_zero  = div_zero_r;
    assign bus.ovf       = ovf_r;
    assign bus.ready     = ready_r;
    assign bus.done_tick = done_tick_r;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed corner cases on an 8-bit,
// 1-bit-per-cycle instance and randomized traffic on a 16-bit,
// 2-bits-per-cycle instance, both checked against an arithmetic model.
`timescale 1ns/1ps
module tb_seq_divider;

    typedef struct {
        logic [31:0] quo;
        logic [31:0] rmd;
        logic        dz;
        logic        ovf;
        int          issue;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset8;
    logic reset16;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q8[$];
    exp_t q16[$];
    exp_t e8;
    exp_t e16;
    logic prev_done8 = 1'b0;
    logic prev_done16 = 1'b0;

    seq_divider_if #(.W(8))  bus8();
    seq_divider_if #(.W(16)) bus16();

    seq_divider #(.W(8), .BPC(1), .SIGNED_EN(1)) u_div8 (
        .clk   (clk),
        .reset (reset8),
        .bus   (bus8.slave)
    );

    seq_divider #(.W(16), .BPC(2), .SIGNED_EN(1)) u_div16 (
        .clk   (clk),
        .reset (reset16),
        .bus   (bus16.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer division of w-bit operands.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input int lat_calc);
        exp_t   e;
        longint mask;
        longint ua;
        longint ub;
        longint sa;
        longint sb;
        mask  = (longint'(1) << w) - 64'sd1;
        ua    = longint'(a) & mask;
        ub    = longint'(b) & mask;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        e.issue = 0;
        if (ub == 0) begin
            e.quo = 32'(mask);
            e.rmd = 32'(ua);
            e.dz  = 1'b1;
            e.lat = 1;
        end else if (s) begin
            sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
            sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
            e.quo = 32'((sa / sb) & mask);
            e.rmd = 32'((sa % sb) & mask);
            e.ovf = (sa == -(longint'(1) << (w - 1))) && (sb == -64'sd1);
            e.lat = lat_calc;
        end else begin
            e.quo = 32'(ua / ub);
            e.rmd = 32'(ua % ub);
            e.lat = lat_calc;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", nm, got, expv, $time);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [31:0] quo,
                       input logic [31:0] rmd, input logic dz, input logic ovf, input int now);
        chk({tag, "_quo"}, quo, e.quo);
        chk({tag, "_rmd"}, rmd, e.rmd);
        chk({tag, "_div_zero"}, 32'(dz), 32'(e.dz));
        chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
        chk({tag, "_latency"}, 32'(now - e.issue), 32'(e.lat));
    endtask

    // Monitor for the 8-bit instance: pops an expectation on every done_tick.
    always @(negedge clk) begin
        if (reset8) begin
            prev_done8 = 1'b0;
        end else begin
            if (prev_done8) begin
                chk("div8_done_one_cycle", 32'(bus8.done_tick), 32'd0);
                chk("div8_ready_after_done", 32'(bus8.ready), 32'd1);
            end
            prev_done8 = bus8.done_tick;
            if (bus8.done_tick) begin
                chk("div8_expected_pending", 32'(q8.size() > 0), 32'd1);
                if (q8.size() > 0) begin
                    e8 = q8.pop_front();
                    cmp("div8", e8, 32'(bus8.quo), 32'(bus8.rmd), bus8.div_zero, bus8.ovf, cyc);
                end
            end
        end
    end

    // Monitor for the 16-bit instance.
    always @(negedge clk) begin
        if (reset16) begin
            prev_done16 = 1'b0;
        end else begin
            if (prev_done16) begin
                chk("div16_done_one_cycle", 32'(bus16.done_tick), 32'd0);
                chk("div16_ready_after_done", 32'(bus16.ready), 32'd1);
            end
            prev_done16 = bus16.done_tick;
            if (bus16.done_tick) begin
                chk("div16_expected_pending", 32'(q16.size() > 0), 32'd1);
                if (q16.size() > 0) begin
                    e16 = q16.pop_front();
                    cmp("div16", e16, 32'(bus16.quo), 32'(bus16.rmd), bus16.div_zero, bus16.ovf, cyc);
                end
            end
        end
    end

    task automatic wait_ready8();
        int n = 0;
        while (bus8.ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("div8_ready_wait", 32'(bus8.ready), 32'd1);
    endtask

    task automatic wait_ready16();
        int n = 0;
        while (bus16.ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("div16_ready_wait", 32'(bus16.ready), 32'd1);
    endtask

    // Issue one 8-bit operation (called at a falling edge); returns in cycle 1.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s, input bit track);
        exp_t e;
        wait_ready8();
        bus8.dvnd      = a;
        bus8.dvsr      = b;
        bus8.signed_op = s;
        bus8.start     = 1'b1;
        e = model(8, 32'(a), 32'(b), s, 10);
        e.issue = cyc;
        if (track) q8.push_back(e);
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic s, input bit track);
        exp_t e;
        wait_ready16();
        bus16.dvnd      = a;
        bus16.dvsr      = b;
        bus16.signed_op = s;
        bus16.start     = 1'b1;
        e = model(16, 32'(a), 32'(b), s, 10);
        e.issue = cyc;
        if (track) q16.push_back(e);
        @(negedge clk);
        bus16.start = 1'b0;
    endtask

    // Safety net in case a wait is broken in a way the budgets do not cover.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        int          mode;
        int          act;
        int          k;

        reset8  = 1'b1;
        reset16 = 1'b1;
        bus8.start = 1'b0;  bus8.abort = 1'b0;  bus8.signed_op = 1'b0;
        bus8.dvnd = 8'h00;  bus8.dvsr = 8'h00;
        bus16.start = 1'b0; bus16.abort = 1'b0; bus16.signed_op = 1'b0;
        bus16.dvnd = 16'h0000; bus16.dvsr = 16'h0000;
        repeat (3) @(negedge clk);
        reset8  = 1'b0;
        reset16 = 1'b0;

        // Reset state.
        chk("rst8_quo", 32'(bus8.quo), 32'd0);
        chk("rst8_rmd", 32'(bus8.rmd), 32'd0);
        chk("rst8_div_zero", 32'(bus8.div_zero), 32'd0);
        chk("rst8_ovf", 32'(bus8.ovf), 32'd0);
        chk("rst8_ready", 32'(bus8.ready), 32'd1);
        chk("rst8_done", 32'(bus8.done_tick), 32'd0);
        chk("rst16_quo", 32'(bus16.quo), 32'd0);
        chk("rst16_ready", 32'(bus16.ready), 32'd1);

        // Directed cases on the 8-bit divider.
        issue8(8'd200, 8'd7, 1'b0, 1'b1);
        issue8(8'h9C, 8'd7, 1'b1, 1'b1);     // -100 / 7
        issue8(8'd100, 8'hF9, 1'b1, 1'b1);   // 100 / -7
        issue8(8'd55, 8'd0, 1'b0, 1'b1);     // divide by zero
        issue8(8'd9, 8'd3, 1'b0, 1'b1);      // flag cleared again
        issue8(8'h9C, 8'd0, 1'b1, 1'b1);     // divide by zero, raw negative dividend
        issue8(8'h80, 8'hFF, 1'b1, 1'b1);    // signed MIN / -1
        issue8(8'h80, 8'hFF, 1'b0, 1'b1);    // same bits, unsigned
        issue8(8'd200, 8'd7, 1'b0, 1'b1);
        wait_ready8();

        // Abort in CALC cycle 3: back to IDLE, no done_tick, results held.
        issue8(8'd250, 8'd3, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        bus8.abort = 1'b1;
        @(negedge clk);
        bus8.abort = 1'b0;
        chk("abort8_ready", 32'(bus8.ready), 32'd1);
        chk("abort8_done", 32'(bus8.done_tick), 32'd0);
        chk("abort8_quo_held", 32'(bus8.quo), 32'd28);
        chk("abort8_rmd_held", 32'(bus8.rmd), 32'd4);
        repeat (14) @(negedge clk);
        chk("abort8_quo_still_held", 32'(bus8.quo), 32'd28);

        // A start pulse while busy must not disturb the operation in flight.
        issue8(8'd100, 8'hF9, 1'b1, 1'b1);
        @(negedge clk);
        bus8.dvnd = 8'd3; bus8.dvsr = 8'd1; bus8.signed_op = 1'b0; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        wait_ready8();

        // Reset mid-CALC clears outputs without waiting for a clock edge.
        issue8(8'd77, 8'd5, 1'b0, 1'b0);
        @(negedge clk);
        #2 reset8 = 1'b1;
        #1;
        chk("midrst8_quo", 32'(bus8.quo), 32'd0);
        chk("midrst8_rmd", 32'(bus8.rmd), 32'd0);
        chk("midrst8_div_zero", 32'(bus8.div_zero), 32'd0);
        chk("midrst8_ovf", 32'(bus8.ovf), 32'd0);
        chk("midrst8_ready", 32'(bus8.ready), 32'd1);
        chk("midrst8_done", 32'(bus8.done_tick), 32'd0);
        @(negedge clk);
        reset8 = 1'b0;
        issue8(8'd77, 8'd5, 1'b0, 1'b1);
        wait_ready8();

        // Randomized traffic on the 16-bit, 2-bits-per-cycle divider.
        for (int i = 0; i < 1500; i++) begin
            mode = $urandom_range(0, 9);
            s    = 1'($urandom_range(0, 1));
            a    = 16'($urandom);
            b    = 16'($urandom);
            case (mode)
                0: b = 16'h0000;
                1: begin a = 16'h8000; b = 16'hFFFF; end
                2: b = 16'($urandom_range(1, 15));
                3: a = 16'($urandom_range(0, 300));
                default: ;
            endcase
            act = (b != 16'h0000) ? $urandom_range(0, 7) : 0;
            issue16(a, b, s, act != 1);
            if (act == 1) begin
                // Abort somewhere in CALC (cycles 2..8) or FIX (cycle 9).
                k = $urandom_range(2, 9);
                repeat (k - 1) @(negedge clk);
                bus16.abort = 1'b1;
                @(negedge clk);
                bus16.abort = 1'b0;
                chk("abort16_ready", 32'(bus16.ready), 32'd1);
                chk("abort16_done", 32'(bus16.done_tick), 32'd0);
            end else if (act == 2) begin
                @(negedge clk);
                bus16.dvnd  = 16'($urandom);
                bus16.dvsr  = 16'($urandom_range(1, 65535));
                bus16.start = 1'b1;
                @(negedge clk);
                bus16.start = 1'b0;
            end
        end
        wait_ready16();
        repeat (3) @(negedge clk);

        chk("sb8_drained", 32'(q8.size()), 32'd0);
        chk("sb16_drained", 32'(q16.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
